spi_rx_frame: RTL and testbench

- SPI receive deserializer that sits directly downstream of the serial bit clocking and byte counting stage.
- Samples one serial bit per enabled cycle and assembles bytes MSB-first.
- Tracks a 2-bit byte index (0..3, same 8-cycles-per-byte cadence as the byte counter) and packs four bytes into a 32-bit frame.
- Hands each frame to the register/command logic over a valid/ready handshake, with overrun detection.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_rx_shifter.sv | 40 ++++
 rtl/spi_rx_frame.sv | 122 ++++++++++++
 tb/tb_spi_rx_frame.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI receive path.
// Holds byte/frame geometry and the receive FSM state encoding.
// No ports; imported by spi_rx_shifter and spi_rx_frame.
package spi_pkg;

  localparam int DATA_W          = 8;
  localparam int BYTES_PER_FRAME = 4;
  localparam int FRAME_W         = DATA_W * BYTES_PER_FRAME;
  localparam int BIT_CNT_W       = 3;
  localparam int BYTE_IDX_W      = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/spi_rx_shifter.sv
// Serial-to-parallel byte shifter: MSB-first, one bit per shift_en cycle.
// Ports: clk/rst (sync, active-low), clear aborts the partial byte, shift_en
//   strobes sdi in; byte_next/byte_done present the completing byte combinationally.
module spi_rx_shifter
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              sdi,
  output logic [DATA_W-1:0] byte_next,
  output logic              byte_done
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  // Only the first seven bits of a byte need storage: the eighth is taken
  // straight from sdi on the cycle the byte completes.
  logic [DATA_W-2:0]    shreg;
  logic [BIT_CNT_W-1:0] bit_cnt;

  assign byte_next = {shreg, sdi};
  // clear has priority, so a byte finishing on an abort cycle is never reported.
  assign byte_done = shift_en && !clear && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      shreg   <= byte_next[DATA_W-2:0];
      bit_cnt <= bit_cnt + 1'b1;  // wraps 7 -> 0 at byte end
    end
  end

endmodule

// File: rtl/spi_rx_frame.sv
// SPI receive deserializer: assembles MSB-first bytes into 32-bit frames.
// Ports: clk/rst (sync, active-low), cs_n/sdi/sample_en serial side,
//   byte_out/byte_valid/byte_idx per-byte status, frame_data/frame_valid/
//   frame_ready handshake, overrun (sticky), busy (in SHIFT state).
module spi_rx_frame
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs_n,
  input  logic                  sdi,
  input  logic                  sample_en,
  input  logic                  frame_ready,
  output logic [DATA_W-1:0]     byte_out,
  output logic                  byte_valid,
  output logic [BYTE_IDX_W-1:0] byte_idx,
  output logic [FRAME_W-1:0]    frame_data,
  output logic                  frame_valid,
  output logic                  overrun,
  output logic                  busy
);

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_FRAME - 1);

  rx_state_e state;
  rx_state_e state_nxt;

  logic                                  shift_en;
  logic [DATA_W-1:0]                     byte_next;
  logic                                  byte_done;
  logic                                  frame_done;
  logic                                  accept;
  logic [BYTES_PER_FRAME-1:0][DATA_W-1:0] asm_buf;
  logic [FRAME_W-1:0]                    frame_next;

  // Sampling is enabled whenever cs_n is low: in SHIFT, and also on the IDLE
  // entry cycle. cs_n high always aborts, so it doubles as the shifter clear.
  assign shift_en = sample_en && !cs_n;

  spi_rx_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .clear     (cs_n),
    .shift_en  (shift_en),
    .sdi       (sdi),
    .byte_next (byte_next),
    .byte_done (byte_done)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!cs_n) state_nxt = SHIFT;
      SHIFT:   if (cs_n)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = 1'b0;
    if (state == SHIFT) busy = 1'b1;
  end

  // Frame image with the completing byte patched into the last slot; slot 0
  // (first byte received) lands in the top bits.
  always_comb begin
    frame_next = '0;
    for (int i = 0; i < BYTES_PER_FRAME; i++) begin
      if (i == BYTES_PER_FRAME - 1)
        frame_next[FRAME_W-1-i*DATA_W -: DATA_W] = byte_next;
      else
        frame_next[FRAME_W-1-i*DATA_W -: DATA_W] = asm_buf[i];
    end
  end

  assign frame_done = byte_done && (byte_idx == LAST_IDX);
  assign accept     = frame_valid && frame_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_out    <= '0;
      byte_valid  <= 1'b0;
      byte_idx    <= '0;
      asm_buf     <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      byte_valid <= byte_done;

      if (byte_done) begin
        byte_out          <= byte_next;
        asm_buf[byte_idx] <= byte_next;
        byte_idx          <= byte_idx + 1'b1;  // wraps 3 -> 0
      end else if (cs_n) begin
        // Abort: partial frame is dropped; stale slots are overwritten before reuse.
        byte_idx <= '0;
      end

      // A same-cycle accept frees the register, so the new frame may load.
      if (frame_done) begin
        if (!frame_valid || frame_ready) begin
          frame_data  <= frame_next;
          frame_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (accept) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_rx_frame.sv
// Directed self-checking bench for spi_rx_frame.
// Drives inputs and samples outputs 1 time unit after each rising edge.
module tb_spi_rx_frame;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n;
  logic        sdi;
  logic        sample_en;
  logic        frame_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic [1:0]  byte_idx;
  logic [31:0] frame_data;
  logic        frame_valid;
  logic        overrun;
  logic        busy;

  int checks = 0;
  int errors = 0;

  spi_rx_frame dut (
    .clk         (clk),
    .rst         (rst),
    .cs_n        (cs_n),
    .sdi         (sdi),
    .sample_en   (sample_en),
    .frame_ready (frame_ready),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .byte_idx    (byte_idx),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shift one byte MSB-first; 'gap' idle cycles precede every strobe.
  // Returns right after the edge that takes the 8th bit, with sample_en still 1.
  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 7; i >= 0; i--) begin
      sample_en = 1'b0;
      repeat (gap) tick();
      sdi       = b[i];
      sample_en = 1'b1;
      tick();
    end
  endtask

  initial begin
    logic [7:0] tmp;

    // 1. Reset dominates cs_n=0 / sample_en=1
    rst = 1'b0; cs_n = 1'b0; sample_en = 1'b1; sdi = 1'b1; frame_ready = 1'b0;
    repeat (3) tick();
    chk("rst_byte_out",    byte_out,    32'h0);
    chk("rst_byte_valid",  byte_valid,  32'h0);
    chk("rst_byte_idx",    byte_idx,    32'h0);
    chk("rst_frame_data",  frame_data,  32'h0);
    chk("rst_frame_valid", frame_valid, 32'h0);
    chk("rst_overrun",     overrun,     32'h0);
    chk("rst_busy",        busy,        32'h0);
    rst = 1'b1;
    tick();
    chk("rel_busy", busy, 32'h1);
    cs_n = 1'b1; sample_en = 1'b0;
    tick();
    chk("idle_busy", busy, 32'h0);

    // 2. Single frame A5 3C F0 0F, consumer always ready
    frame_ready = 1'b1; cs_n = 1'b0;
    send_byte(8'hA5, 0);
    chk("b0_valid", byte_valid, 32'h1);
    chk("b0_out",   byte_out,   32'hA5);
    chk("b0_idx",   byte_idx,   32'h1);
    send_byte(8'h3C, 0);
    chk("b1_out",   byte_out,   32'h3C);
    send_byte(8'hF0, 0);
    chk("b2_out",   byte_out,   32'hF0);
    send_byte(8'h0F, 0);
    chk("b3_valid", byte_valid, 32'h1);
    chk("b3_out",   byte_out,   32'h0F);
    chk("f0_valid", frame_valid, 32'h1);
    chk("f0_data",  frame_data,  32'hA53CF00F);
    chk("f0_idx",   byte_idx,    32'h0);
    sample_en = 1'b0;
    tick();
    chk("f0_valid_drop", frame_valid, 32'h0);
    chk("b3_valid_drop", byte_valid,  32'h0);

    // 3. Backpressure and overrun
    frame_ready = 1'b0;
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    chk("bp_valid1",   frame_valid, 32'h1);
    chk("bp_data1",    frame_data,  32'h11223344);
    chk("bp_ovr1",     overrun,     32'h0);
    send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0); send_byte(8'h88, 0);
    chk("bp_data2",    frame_data,  32'h11223344);
    chk("bp_valid2",   frame_valid, 32'h1);
    chk("bp_ovr2",     overrun,     32'h1);
    sample_en = 1'b0; frame_ready = 1'b1;
    tick();
    chk("bp_accept",   frame_valid, 32'h0);
    chk("bp_ovr_stk",  overrun,     32'h1);
    frame_ready = 1'b0;

    // 4. Accept coincides with a new completion
    rst = 1'b0; cs_n = 1'b1;
    tick();
    rst = 1'b1;
    chk("rst2_ovr", overrun, 32'h0);
    cs_n = 1'b0;
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    chk("sim_valid1", frame_valid, 32'h1);
    send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0);
    tmp = 8'hEF;
    for (int i = 7; i >= 0; i--) begin
      sdi = tmp[i];
      sample_en = 1'b1;
      if (i == 0) frame_ready = 1'b1;
      tick();
    end
    chk("sim_data",  frame_data,  32'hDEADBEEF);
    chk("sim_valid", frame_valid, 32'h1);
    chk("sim_ovr",   overrun,     32'h0);
    frame_ready = 1'b0; sample_en = 1'b0;
    tick();
    chk("sim_hold",  frame_valid, 32'h1);
    frame_ready = 1'b1;
    tick();
    chk("sim_drain", frame_valid, 32'h0);

    // 5. Abort after 5 bits of byte 2, then abort on a completing bit
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    chk("ab_idx2", byte_idx, 32'h2);
    tmp = 8'h56;
    for (int i = 7; i >= 3; i--) begin
      sdi = tmp[i];
      tick();
    end
    cs_n = 1'b1; sdi = 1'b1;
    tick();
    chk("ab_busy",   busy,        32'h0);
    chk("ab_idx",    byte_idx,    32'h0);
    chk("ab_bvalid", byte_valid,  32'h0);
    chk("ab_fvalid", frame_valid, 32'h0);
    cs_n = 1'b0; sdi = 1'b1;
    repeat (7) tick();
    cs_n = 1'b1;
    tick();
    chk("ab8_bvalid", byte_valid, 32'h0);
    chk("ab8_out",    byte_out,   32'h34);
    sample_en = 1'b0;
    tick();
    cs_n = 1'b0;
    send_byte(8'hCA, 0); send_byte(8'hFE, 0); send_byte(8'hF0, 0); send_byte(8'h0D, 0);
    chk("re_valid", frame_valid, 32'h1);
    chk("re_data",  frame_data,  32'hCAFEF00D);
    sample_en = 1'b0;
    tick();
    chk("re_drain", frame_valid, 32'h0);

    // 6. Gapped strobes: one strobe every third cycle
    send_byte(8'h81, 2);
    chk("gap_valid", byte_valid, 32'h1);
    chk("gap_out",   byte_out,   32'h81);
    chk("gap_idx",   byte_idx,   32'h1);
    sample_en = 1'b0;
    tick();
    chk("gap_pulse", byte_valid, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
